calc_alu_seq: RTL

CALC_ALU_SEQ -- requirements
Module: calc_alu_seq

---
 rtl/calc_alu_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/calc_alu_seq.sv
// Sequential add/sub/mul ALU with a valid/ready request and result handshake.
// Define CALC_ALU_MUL_EN to build the shift-add multiplier; otherwise op 10 is reserved.
module calc_alu_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RES_W = 2 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             err
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;

`ifdef CALC_ALU_MUL_EN
  localparam logic [1:0] OpMul = 2'b10;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  logic [RES_W-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [RES_W-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             alu_mul;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDone = 2'd2
  } state_e;
`endif

  state_e           state_q;
  logic [RES_W-1:0] alu_res;
  logic             alu_err;

  assign in_ready = (state_q == StIdle);

  // Single-cycle ops are resolved straight from the request inputs at accept.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
`ifdef CALC_ALU_MUL_EN
    alu_mul = 1'b0;
`endif
    unique case (op)
      OpAdd: alu_res = RES_W'(operand1) + RES_W'(operand2);
      OpSub: alu_res = RES_W'(operand1) - RES_W'(operand2);
`ifdef CALC_ALU_MUL_EN
      OpMul: alu_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      result    <= '0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      err       <= 1'b0;
`ifdef CALC_ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
`ifdef CALC_ALU_MUL_EN
            if (alu_mul) begin
              state_q  <= StCalc;
              mcand_q  <= RES_W'(operand1);
              mplier_q <= operand2;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else
`endif
            begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= alu_res;
              flag_zero <= (alu_res == '0);
              flag_neg  <= alu_res[RES_W-1];
              err       <= alu_err;
            end
          end
        end
`ifdef CALC_ALU_MUL_EN
        // WIDTH shift-add steps, then one cycle to publish the product.
        StCalc: begin
          if (cnt_q == CntW'(WIDTH)) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= acc_q;
            flag_zero <= (acc_q == '0);
            flag_neg  <= acc_q[RES_W-1];
            err       <= 1'b0;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
          end
        end
`endif
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
